reaction_stats: RTL

//  Consumes reaction FSM state/tick count in the 50 MHz domain, converts each completed

---
 rtl/reaction_stats.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_stats.sv
// rtl/reaction_stats.sv - reaction time statistics: ticks to ms, last/best/average as packed BCD
//
// Purpose:
//   Watches the reaction FSM state. On each rising edge of state==3'b100 the
//   measured tick count is divided down to milliseconds. The block then keeps the
//   last result, the best (minimum) result and the mean of the last AVG_N
//   results, and presents all three as packed 4-digit BCD
//   ([15:12] thousands .. [3:0] units) for glyph rendering.
//   All BCD outputs change together in the single cycle where o_valid pulses.
//
// Ports:
//   i_clk_50m   in   system clock
//   i_rst_n     in   asynchronous active-low reset
//   i_state     in   reaction FSM state, 3'b100 = result ready
//   i_ticks     in   measured ticks, sampled on the trigger cycle
//   o_busy      out  conversion in progress (trigger+1 through the o_valid cycle)
//   o_valid     out  1-cycle pulse, all BCD outputs updated this cycle
//   o_last_bcd  out  last result, BCD ms
//   o_best_bcd  out  best result, BCD ms
//   o_avg_bcd   out  average of last AVG_N results, BCD ms (16'hFFFF until o_avg_ok)
//   o_avg_ok    out  AVG_N results accumulated
//   o_count     out  accepted results, saturating at 255
//
// Configuration:
//   REACTION_STATS_ROUND_EN  when defined, adds TICKS_MS/2 (saturating) to the
//                            dividend so the ms value rounds to nearest.

module reaction_stats #(
  parameter int TICKS_W  = 28,
  parameter int TICKS_MS = 50000,
  parameter int MS_W     = 13,
  parameter int AVG_N    = 4
) (
  input  logic               i_clk_50m,
  input  logic               i_rst_n,
  input  logic [2:0]         i_state,
  input  logic [TICKS_W-1:0] i_ticks,
  output logic               o_busy,
  output logic               o_valid,
  output logic [15:0]        o_last_bcd,
  output logic [15:0]        o_best_bcd,
  output logic [15:0]        o_avg_bcd,
  output logic               o_avg_ok,
  output logic [7:0]         o_count
);

  localparam logic [2:0] ST_RESULT = 3'b100;
  localparam int REM_W  = $clog2(TICKS_MS);
  localparam int DCNT_W = $clog2(TICKS_W + 1);
  localparam int BCNT_W = $clog2(MS_W + 1);
  localparam int PTR_W  = $clog2(AVG_N);
  localparam int SUM_W  = MS_W + PTR_W;
  localparam logic [REM_W:0]    DIVISOR   = (REM_W + 1)'(TICKS_MS);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(TICKS_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MS_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_UPD, S_BCD_L, S_BCD_B, S_BCD_A, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                trig_prev_q, trig_prev_d;
  logic [TICKS_W-1:0]  work_q, work_d;     // dividend shifts out of the top, quotient in at the bottom
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [MS_W-1:0]     bin_q, bin_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [MS_W-1:0]     last_ms_q, last_ms_d;
  logic [MS_W-1:0]     best_ms_q, best_ms_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [MS_W-1:0]     entries_q [AVG_N];
  logic [MS_W-1:0]     entries_d [AVG_N];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [7:0]          count_q, count_d;
  logic [15:0]         last_sh_q, last_sh_d;
  logic [15:0]         best_sh_q, best_sh_d;
  logic [15:0]         last_bcd_q, last_bcd_d;
  logic [15:0]         best_bcd_q, best_bcd_d;
  logic [15:0]         avg_bcd_q, avg_bcd_d;
  logic                avg_ok_q, avg_ok_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [TICKS_W-1:0]  dividend;
  logic                trig;
  logic [REM_W:0]      rem_shift;
  logic                rem_ge;
  logic [MS_W-1:0]     q_ms;
  logic [MS_W-1:0]     avg_ms;
  logic [15:0]         bcd_adj;
  logic [15:0]         bcd_step;
  logic [MS_W-1:0]     bin_step;
  logic                avg_ok_new;

`ifdef REACTION_STATS_ROUND_EN
  localparam int HALF_MS = TICKS_MS / 2;
  logic [TICKS_W:0] ticks_rnd;
  always_comb begin
    ticks_rnd = {1'b0, i_ticks} + HALF_MS[TICKS_W:0];
    dividend  = ticks_rnd[TICKS_W] ? '1 : ticks_rnd[TICKS_W-1:0];
  end
`else
  assign dividend = i_ticks;
`endif

  assign trig = (i_state == ST_RESULT) && !trig_prev_q;

  // One restoring-division step per cycle.
  assign rem_shift = {rem_q, work_q[TICKS_W-1]};
  assign rem_ge    = (rem_shift >= DIVISOR);

  // Quotient bits above MS_W cannot be shown; clamp instead of wrapping.
  assign q_ms   = (|work_q[TICKS_W-1:MS_W]) ? '1 : work_q[MS_W-1:0];
  assign avg_ms = MS_W'(sum_q >> PTR_W);
  assign avg_ok_new = (count_q >= 8'(AVG_N));

  // Double-dabble iteration: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_step = 16'({bcd_adj, bin_q[MS_W-1]});
    bin_step = {bin_q[MS_W-2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    trig_prev_d = (i_state == ST_RESULT);
    work_d      = work_q;
    rem_d       = rem_q;
    dcnt_d      = dcnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    bcnt_d      = bcnt_q;
    last_ms_d   = last_ms_q;
    best_ms_d   = best_ms_q;
    sum_d       = sum_q;
    entries_d   = entries_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    last_sh_d   = last_sh_q;
    best_sh_d   = best_sh_q;
    last_bcd_d  = last_bcd_q;
    best_bcd_d  = best_bcd_q;
    avg_bcd_d   = avg_bcd_q;
    avg_ok_d    = avg_ok_q;
    valid_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A timeout marker (all-ones ticks) is not a measurement.
        if (trig && (i_ticks != '1)) begin
          work_d  = dividend;
          rem_d   = '0;
          dcnt_d  = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = rem_ge ? REM_W'(rem_shift - DIVISOR) : REM_W'(rem_shift);
        work_d = {work_q[TICKS_W-2:0], rem_ge};
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_LAST) begin
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        last_ms_d = q_ms;
        if (q_ms < best_ms_q) begin
          best_ms_d = q_ms;
        end
        sum_d            = sum_q - SUM_W'(entries_q[ptr_q]) + SUM_W'(q_ms);
        entries_d[ptr_q] = q_ms;
        ptr_d            = ptr_q + 1'b1;
        if (count_q != 8'hFF) begin
          count_d = count_q + 8'd1;
        end
        bin_d   = q_ms;
        bcd_d   = '0;
        bcnt_d  = '0;
        state_d = S_BCD_L;
      end
      S_BCD_L, S_BCD_B, S_BCD_A: begin
        bcd_d  = bcd_step;
        bin_d  = bin_step;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BCNT_LAST) begin
          bcd_d  = '0;
          bcnt_d = '0;
          if (state_q == S_BCD_L) begin
            last_sh_d = bcd_step;
            bin_d     = best_ms_q;
            state_d   = S_BCD_B;
          end else if (state_q == S_BCD_B) begin
            best_sh_d = bcd_step;
            bin_d     = avg_ms;
            state_d   = S_BCD_A;
          end else begin
            // The average conversion finishes here, so all outputs load on this edge.
            last_bcd_d = last_sh_q;
            best_bcd_d = best_sh_q;
            avg_bcd_d  = avg_ok_new ? bcd_step : 16'hFFFF;
            avg_ok_d   = avg_ok_new;
            valid_d    = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      work_q      <= '0;
      rem_q       <= '0;
      dcnt_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      bcnt_q      <= '0;
      last_ms_q   <= '0;
      best_ms_q   <= '1;
      sum_q       <= '0;
      for (int i = 0; i < AVG_N; i++) begin
        entries_q[i] <= '0;
      end
      ptr_q       <= '0;
      count_q     <= '0;
      last_sh_q   <= 16'hFFFF;
      best_sh_q   <= 16'hFFFF;
      last_bcd_q  <= 16'hFFFF;
      best_bcd_q  <= 16'hFFFF;
      avg_bcd_q   <= 16'hFFFF;
      avg_ok_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dcnt_q      <= dcnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      bcnt_q      <= bcnt_d;
      last_ms_q   <= last_ms_d;
      best_ms_q   <= best_ms_d;
      sum_q       <= sum_d;
      entries_q   <= entries_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      last_sh_q   <= last_sh_d;
      best_sh_q   <= best_sh_d;
      last_bcd_q  <= last_bcd_d;
      best_bcd_q  <= best_bcd_d;
      avg_bcd_q   <= avg_bcd_d;
      avg_ok_q    <= avg_ok_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_last_bcd = last_bcd_q;
  assign o_best_bcd = best_bcd_q;
  assign o_avg_bcd  = avg_bcd_q;
  assign o_avg_ok   = avg_ok_q;
  assign o_count    = count_q;

endmodule
